// File: rtl/vx_jal_overload_ctl_pkg.sv
// Shared types and CSR layout for the JAL-overload
// thread-transfer controller.
package vx_jal_overload_ctl_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_DONE  = 2'd2,
      S_CLEAR = 2'd3
   } jal_ovl_state_t;

   localparam logic [1:0] CSR_RAVW0  = 2'd0;
   localparam logic [1:0] CSR_RAV    = 2'd1;
   localparam logic [1:0] CSR_JALOL  = 2'd2;
   localparam logic [1:0] CSR_STATUS = 2'd3;

   localparam int ST_STATE_LSB = 0;
   localparam int ST_STATE_W   = 2;
   localparam int ST_ERR_BIT   = 2;
   localparam int ST_MASK_LSB  = 3;

endpackage

// File: rtl/vx_jal_overload_ctl_if.sv
// Request/completion handshake between the interrupt
// controller (master) and the JAL-overload controller (slave).
interface vx_jal_overload_ctl_if #(
   parameter int WARP_CNT = 4,
   parameter int XLEN     = 32
);

   logic                itr_req_valid;
   logic                itr_req_ready;
   logic [XLEN-1:0]     itr_req_rha;
   logic [WARP_CNT-1:0] itr_req_mask;
   logic                done_valid;
   logic                done_err;
   logic                done_ready;

   modport master (
      output itr_req_valid,
      output itr_req_rha,
      output itr_req_mask,
      output done_ready,
      input  itr_req_ready,
      input  done_valid,
      input  done_err
   );

   modport slave (
      input  itr_req_valid,
      input  itr_req_rha,
      input  itr_req_mask,
      input  done_ready,
      output itr_req_ready,
      output done_valid,
      output done_err
   );

endinterface

// File: rtl/vx_jal_ovl_ravfile.sv
// Return-address store: one entry per warp plus a dedicated
// warp-0 entry; entry 0 of the array is never written.
module vx_jal_ovl_ravfile #(
   parameter int WARP_CNT = 4,
   parameter int XLEN     = 32,
   parameter int WL       = $clog2(WARP_CNT)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            we,
   input  logic [WL-1:0]   wid,
   input  logic [XLEN-1:0] wdata,
   input  logic            we_w0,
   input  logic [XLEN-1:0] wdata_w0,
   input  logic [WL-1:0]   rd_wid,
   output logic [XLEN-1:0] rd_data,
   output logic [XLEN-1:0] rd_w0
);

   logic [XLEN-1:0] rav [WARP_CNT];
   logic [XLEN-1:0] rav_w0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < WARP_CNT; i++) begin
            rav[i] <= '0;
         end
      end else if (we && (wid != '0)) begin
         rav[wid] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rav_w0 <= '0;
      end else if (we_w0) begin
         rav_w0 <= wdata_w0;
      end
   end

   assign rd_data = rav[rd_wid];
   assign rd_w0   = rav_w0;

endmodule

// File: rtl/vx_jal_overload_ctl.sv
// Arms per-warp JAL overloading for a thread transfer, records
// return addresses, and reports completion or timeout.
module vx_jal_overload_ctl
   import vx_jal_overload_ctl_pkg::*;
#(
   parameter int WARP_CNT       = 4,
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int WL             = $clog2(WARP_CNT)
) (
   input  logic                clk,
   input  logic                reset_n,
   vx_jal_overload_ctl_if.slave itr,
   output logic [WARP_CNT-1:0] overload_jal,
   output logic [XLEN-1:0]     ret_handler_addr,
   input  logic                commit_ret_pc,
   input  logic [WL-1:0]       ret_pc_wid,
   input  logic [XLEN-1:0]     ret_pc,
   input  logic                commit_ret_pc_w0,
   input  logic [XLEN-1:0]     ret_pc_w0,
   input  logic [WARP_CNT-1:0] warp_hits,
   output logic                hits_clear,
   input  logic [1:0]          csr_addr,
   input  logic [WL-1:0]       csr_wid,
   output logic [XLEN-1:0]     csr_rdata
);

   localparam int TW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   jal_ovl_state_t      state;
   jal_ovl_state_t      state_nxt;
   logic [WARP_CNT-1:0] mask_q;
   logic [WARP_CNT-1:0] mask_nxt;
   logic [TW-1:0]       timer;
   logic                err_q;
   logic                req_fire;
   logic                done_fire;
   logic                all_hit;
   logic                timed_out;
   logic                armed;
   logic [XLEN-1:0]     rav_rd;
   logic [XLEN-1:0]     rav_w0;

   assign armed     = (state == S_ARMED);
   assign req_fire  = itr.itr_req_valid & (state == S_IDLE);
   assign done_fire = itr.done_ready & (state == S_DONE);
   assign all_hit   = ((warp_hits & mask_q) == mask_q);
   assign timed_out = (TIMEOUT_CYCLES != 0) &&
                      (timer == TW'(TIMEOUT_CYCLES - 1));
   assign mask_nxt  = req_fire ? itr.itr_req_mask : mask_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // completion wins over a timeout landing in the same cycle
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (req_fire) begin
               state_nxt = (itr.itr_req_mask == '0) ?
                           S_DONE : S_ARMED;
            end
         end
         S_ARMED: begin
            if (all_hit || timed_out) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (done_fire) begin
               state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      itr.itr_req_ready = (state == S_IDLE);
      itr.done_valid    = (state == S_DONE);
      itr.done_err      = err_q;
      hits_clear        = (state == S_CLEAR);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q           <= '0;
         ret_handler_addr <= '0;
      end else if (req_fire) begin
         mask_q           <= itr.itr_req_mask;
         ret_handler_addr <= itr.itr_req_rha;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overload_jal <= '0;
      end else if (state_nxt == S_ARMED) begin
         overload_jal <= mask_nxt & ~warp_hits;
      end else begin
         overload_jal <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer <= '0;
      end else if (armed && (state_nxt == S_ARMED)) begin
         if (timer != '1) begin
            timer <= timer + TW'(1);
         end
      end else begin
         timer <= '0;
      end
   end

   // error flag lives only for the DONE phase it describes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 1'b0;
      end else if (state_nxt != S_DONE) begin
         err_q <= 1'b0;
      end else if (state != S_DONE) begin
         err_q <= armed & ~all_hit;
      end
   end

   vx_jal_ovl_ravfile #(
      .WARP_CNT (WARP_CNT),
      .XLEN     (XLEN),
      .WL       (WL)
   ) u_ravfile (
      .clk      (clk),
      .reset_n  (reset_n),
      .we       (armed & commit_ret_pc),
      .wid      (ret_pc_wid),
      .wdata    (ret_pc),
      .we_w0    (armed & commit_ret_pc_w0),
      .wdata_w0 (ret_pc_w0),
      .rd_wid   (csr_wid),
      .rd_data  (rav_rd),
      .rd_w0    (rav_w0)
   );

   always_comb begin
      csr_rdata = '0;
      unique case (1'b1)
         (csr_addr == CSR_RAVW0): csr_rdata = rav_w0;
         (csr_addr == CSR_RAV):   csr_rdata = rav_rd;
         (csr_addr == CSR_JALOL): begin
            csr_rdata[WARP_CNT-1:0] = overload_jal;
         end
         (csr_addr == CSR_STATUS): begin
            csr_rdata[ST_STATE_LSB +: ST_STATE_W] = state;
            csr_rdata[ST_ERR_BIT] = err_q;
            csr_rdata[ST_MASK_LSB +: WARP_CNT] = mask_q;
         end
         default: csr_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_vx_jal_overload_ctl.sv
// Directed bench with a behavioural model of the controller.
module tb_vx_jal_overload_ctl;

   localparam int W   = 4;
   localparam int X   = 32;
   localparam int TMO = 8;

   localparam int P_IDLE  = 0;
   localparam int P_ARMED = 1;
   localparam int P_DONE  = 2;
   localparam int P_CLEAR = 3;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic [W-1:0] overload_jal;
   logic [X-1:0] ret_handler_addr;
   logic         commit_ret_pc = 1'b0;
   logic [1:0]   ret_pc_wid = '0;
   logic [X-1:0] ret_pc = '0;
   logic         commit_ret_pc_w0 = 1'b0;
   logic [X-1:0] ret_pc_w0 = '0;
   logic [W-1:0] warp_hits = '0;
   logic         hits_clear;
   logic [1:0]   csr_addr = '0;
   logic [1:0]   csr_wid = '0;
   logic [X-1:0] csr_rdata;

   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   vx_jal_overload_ctl_if #(.WARP_CNT(W), .XLEN(X)) itr ();

   vx_jal_overload_ctl #(
      .WARP_CNT(W), .XLEN(X), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .itr(itr),
      .overload_jal(overload_jal),
      .ret_handler_addr(ret_handler_addr),
      .commit_ret_pc(commit_ret_pc),
      .ret_pc_wid(ret_pc_wid),
      .ret_pc(ret_pc),
      .commit_ret_pc_w0(commit_ret_pc_w0),
      .ret_pc_w0(ret_pc_w0),
      .warp_hits(warp_hits),
      .hits_clear(hits_clear),
      .csr_addr(csr_addr),
      .csr_wid(csr_wid),
      .csr_rdata(csr_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   // behavioural model
   int           phase = P_IDLE;
   int           armed_n = 0;
   logic [W-1:0] m_mask = '0;
   logic [W-1:0] m_hits = '0;
   logic [X-1:0] m_rha = '0;
   logic         m_err = 1'b0;
   logic [X-1:0] m_ravw0 = '0;
   logic [X-1:0] m_rav [4] = '{default: '0};

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase   <= P_IDLE;
         armed_n <= 0;
         m_mask  <= '0;
         m_hits  <= '0;
         m_rha   <= '0;
         m_err   <= 1'b0;
         m_ravw0 <= '0;
         for (int i = 0; i < 4; i++) m_rav[i] <= '0;
      end else begin
         m_hits <= warp_hits;
         if (phase == P_IDLE && itr.itr_req_valid) begin
            m_mask  <= itr.itr_req_mask;
            m_rha   <= itr.itr_req_rha;
            armed_n <= 0;
            m_err   <= 1'b0;
            phase   <= (itr.itr_req_mask == 0) ? P_DONE : P_ARMED;
         end else if (phase == P_ARMED) begin
            armed_n <= armed_n + 1;
            if (commit_ret_pc && ret_pc_wid != 0)
               m_rav[ret_pc_wid] <= ret_pc;
            if (commit_ret_pc_w0) m_ravw0 <= ret_pc_w0;
            if ((warp_hits & m_mask) == m_mask) begin
               phase <= P_DONE;
               m_err <= 1'b0;
            end else if (armed_n + 1 == TMO) begin
               phase <= P_DONE;
               m_err <= 1'b1;
            end
         end else if (phase == P_DONE && itr.done_ready) begin
            phase <= P_CLEAR;
            m_err <= 1'b0;
         end else if (phase == P_CLEAR) begin
            phase <= P_IDLE;
         end
      end
   end

   logic [W-1:0] e_ovl;
   logic [X-1:0] e_csr;
   logic [X-1:0] a_csr;

   always @(negedge clk) begin
      if (chk_en) begin
         e_ovl = (phase == P_ARMED) ? (m_mask & ~m_hits) : '0;
         a_csr = csr_rdata;
         case (csr_addr)
            2'd0: e_csr = m_ravw0;
            2'd1: e_csr = m_rav[csr_wid];
            2'd2: e_csr = 32'(e_ovl);
            default: begin
               e_csr = (32'(m_mask) << 3) | (32'(m_err) << 2);
               a_csr = csr_rdata & 32'hFFFF_FFFC;
            end
         endcase
         chk("m_ready", 32'(itr.itr_req_ready), 32'(phase == P_IDLE));
         chk("m_done_valid", 32'(itr.done_valid), 32'(phase == P_DONE));
         chk("m_hits_clear", 32'(hits_clear), 32'(phase == P_CLEAR));
         chk("m_ovl", 32'(overload_jal), 32'(e_ovl));
         chk("m_rha", ret_handler_addr, m_rha);
         chk("m_csr", a_csr, e_csr);
         if (phase == P_DONE)
            chk("m_done_err", 32'(itr.done_err), 32'(m_err));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
      csr_addr = csr_addr + 2'd1;
      if (csr_addr == 2'd0) csr_wid = csr_wid + 2'd1;
   endtask

   task automatic rd(input logic [1:0] a, input logic [1:0] w,
                     input logic [31:0] exp, input string nm);
      csr_addr = a;
      csr_wid  = w;
      #1;
      chk(nm, csr_rdata, exp);
   endtask

   task automatic req(input logic [3:0] m, input logic [31:0] rha);
      itr.itr_req_valid = 1'b1;
      itr.itr_req_mask  = m;
      itr.itr_req_rha   = rha;
      tick();
      itr.itr_req_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      itr.itr_req_valid = 1'b0;
      itr.itr_req_mask  = '0;
      itr.itr_req_rha   = '0;
      itr.done_ready    = 1'b0;
      #1 reset_n = 1'b0;
      #2;
      chk("rst_ovl", 32'(overload_jal), 32'h0);
      chk("rst_ready", 32'(itr.itr_req_ready), 32'h1);
      chk("rst_done", 32'(itr.done_valid), 32'h0);
      chk("rst_clr", 32'(hits_clear), 32'h0);
      chk("rst_rha", ret_handler_addr, 32'h0);
      rd(2'd0, 2'd0, 32'h0, "rst_ravw0");
      tick();
      tick();
      reset_n = 1'b1;
      chk_en  = 1'b1;
      tick();

      // full sequence, hits 0,2,1,3
      req(4'b1111, 32'h8000_0100);
      chk("t1_ovl0", 32'(overload_jal), 32'hF);
      warp_hits = 4'b0001;
      commit_ret_pc_w0 = 1'b1;
      ret_pc_w0 = 32'h100;
      tick();
      chk("t1_ovl1", 32'(overload_jal), 32'hE);
      commit_ret_pc_w0 = 1'b0;
      warp_hits = 4'b0101;
      commit_ret_pc = 1'b1;
      ret_pc_wid = 2'd2;
      ret_pc = 32'h200;
      tick();
      chk("t1_ovl2", 32'(overload_jal), 32'hA);
      warp_hits = 4'b0111;
      ret_pc_wid = 2'd1;
      ret_pc = 32'h300;
      tick();
      chk("t1_ovl3", 32'(overload_jal), 32'h8);
      warp_hits = 4'b1111;
      ret_pc_wid = 2'd3;
      ret_pc = 32'h400;
      tick();
      commit_ret_pc = 1'b0;
      chk("t1_ovl4", 32'(overload_jal), 32'h0);
      chk("t1_done", 32'(itr.done_valid), 32'h1);
      chk("t1_err", 32'(itr.done_err), 32'h0);
      rd(2'd0, 2'd0, 32'h100, "t1_ravw0");
      rd(2'd1, 2'd2, 32'h200, "t1_rav2");
      rd(2'd1, 2'd1, 32'h300, "t1_rav1");
      tick();
      rd(2'd1, 2'd3, 32'h400, "t1_rav3");
      rd(2'd2, 2'd0, 32'h0, "t1_jalol");
      csr_addr = 2'd3;
      #1 chk("t1_status", csr_rdata & 32'hFFFF_FFFC, 32'h78);
      chk("t1_rha", ret_handler_addr, 32'h8000_0100);
      itr.done_ready = 1'b1;
      tick();
      itr.done_ready = 1'b0;
      chk("t1_clr", 32'(hits_clear), 32'h1);
      warp_hits = '0;
      tick();
      chk("t1_clr_end", 32'(hits_clear), 32'h0);
      chk("t1_idle", 32'(itr.itr_req_ready), 32'h1);

      // empty mask
      req(4'b0000, 32'h0000_0040);
      chk("t2_done", 32'(itr.done_valid), 32'h1);
      chk("t2_err", 32'(itr.done_err), 32'h0);
      chk("t2_ovl", 32'(overload_jal), 32'h0);
      itr.done_ready = 1'b1;
      tick();
      itr.done_ready = 1'b0;
      tick();

      // timeout after 8 armed cycles, then held DONE
      req(4'b0011, 32'h0000_1234);
      warp_hits = 4'b0001;
      n = 0;
      while (!itr.done_valid && n < 20) begin
         if (n == 1) chk("t3_ovl", 32'(overload_jal), 32'h2);
         n++;
         tick();
      end
      chk("t3_armed_cycles", n, 8);
      chk("t3_err", 32'(itr.done_err), 32'h1);
      chk("t3_ovl_done", 32'(overload_jal), 32'h0);
      itr.itr_req_valid = 1'b1;
      itr.itr_req_mask  = 4'b1111;
      itr.itr_req_rha   = 32'hDEAD;
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_valid", 32'(itr.done_valid), 32'h1);
         chk("t3_hold_ready", 32'(itr.itr_req_ready), 32'h0);
         tick();
      end
      itr.itr_req_valid = 1'b0;
      chk("t3_rha_kept", ret_handler_addr, 32'h1234);
      csr_addr = 2'd3;
      #1 chk("t3_status", csr_rdata & 32'hFFFF_FFFC, 32'h1C);
      itr.done_ready = 1'b1;
      tick();
      itr.done_ready = 1'b0;
      warp_hits = '0;
      tick();

      // same-cycle writes, wid 0 ignored, then reset in ARMED
      req(4'b1000, 32'h0000_4000);
      commit_ret_pc = 1'b1;
      ret_pc_wid = 2'd3;
      ret_pc = 32'hAAAA;
      commit_ret_pc_w0 = 1'b1;
      ret_pc_w0 = 32'hBBBB;
      tick();
      ret_pc_wid = 2'd0;
      ret_pc = 32'hCCCC;
      commit_ret_pc_w0 = 1'b0;
      rd(2'd1, 2'd3, 32'hAAAA, "t4_rav3");
      rd(2'd0, 2'd0, 32'hBBBB, "t4_ravw0");
      tick();
      commit_ret_pc = 1'b0;
      rd(2'd0, 2'd0, 32'hBBBB, "t4_ravw0_kept");
      rd(2'd1, 2'd0, 32'h0, "t4_rav0");
      reset_n = 1'b0;
      #1;
      chk("t5_ovl", 32'(overload_jal), 32'h0);
      chk("t5_ready", 32'(itr.itr_req_ready), 32'h1);
      chk("t5_done", 32'(itr.done_valid), 32'h0);
      chk("t5_rha", ret_handler_addr, 32'h0);
      rd(2'd0, 2'd0, 32'h0, "t5_ravw0");
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      req(4'b0101, 32'h0000_5555);
      chk("t5_ovl_new", 32'(overload_jal), 32'h5);
      warp_hits = 4'b0101;
      tick();
      chk("t5_done_new", 32'(itr.done_valid), 32'h1);
      itr.done_ready = 1'b1;
      tick();
      itr.done_ready = 1'b0;
      chk("t5_clr", 32'(hits_clear), 32'h1);
      warp_hits = '0;
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
